// File: rtl/cbfp_block_norm_if.sv
// Stream bundle for cbfp_block_norm: complex samples in, normalised samples plus block exponent out.
// Both directions use valid/ready; the slave modport is the normaliser's view.
interface cbfp_block_norm_if #(
  parameter int IN_WIDTH    = 25,
  parameter int OUT_WIDTH   = 12,
  parameter int SHIFT_WIDTH = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [IN_WIDTH-1:0]    in_re;
  logic signed [IN_WIDTH-1:0]    in_im;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_WIDTH-1:0]   out_re;
  logic signed [OUT_WIDTH-1:0]   out_im;
  logic                          out_last;
  logic [SHIFT_WIDTH-1:0]        out_shift;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last, out_shift
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last, out_shift
  );
endinterface

// File: rtl/cbfp_block_norm.sv
// Ping-pong block-floating-point normaliser: first output 2 edges after a block's last accept, then 1/cycle;
// in_ready drops only while both banks hold unread data. CBFP_ROUND_EN selects round-half-up with saturation.
module cbfp_block_norm #(
  parameter int IN_WIDTH    = 25,
  parameter int OUT_WIDTH   = 12,
  parameter int BLOCK_LEN   = 16,
  parameter int MAX_SHIFT   = 13,
  parameter int SHIFT_WIDTH = 5
) (
  input logic              clk,
  input logic              rstn,
  cbfp_block_norm_if.slave bus
);
  localparam int AW = $clog2(BLOCK_LEN);
  localparam int CW = $clog2(IN_WIDTH);
  localparam logic [CW-1:0] MIN_INIT  = CW'(IN_WIDTH - 1);
  localparam logic [CW-1:0] SHIFT_CAP = CW'(MAX_SHIFT);
  localparam logic [AW-1:0] LAST_IDX  = AW'(BLOCK_LEN - 1);
`ifdef CBFP_ROUND_EN
  localparam int DW = IN_WIDTH - OUT_WIDTH;
  localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (DW - 1);
`endif

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  bank_st_t                   st_q [2];
  bank_st_t                   st_d [2];
  logic                       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0]              wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [CW-1:0]              min_q, rsb_re, rsb_im, blk_min;
  logic [SHIFT_WIDTH-1:0]     shift_q [2];
  logic signed [IN_WIDTH-1:0] mem_re [2*BLOCK_LEN];
  logic signed [IN_WIDTH-1:0] mem_im [2*BLOCK_LEN];

  logic                       a_vld, a_last;
  logic signed [IN_WIDTH-1:0] a_re, a_im;
  logic [SHIFT_WIDTH-1:0]     a_shift;
  logic                       in_fire, in_last, fetch, fetch_last, a_adv, b_adv;

  function automatic logic [CW-1:0] rsb(input logic signed [IN_WIDTH-1:0] x);
    logic          done;
    logic [CW-1:0] n;
    n    = '0;
    done = 1'b0;
    for (int i = IN_WIDTH - 2; i >= 0; i--) begin
      if (!done && x[i] == x[IN_WIDTH-1]) n = n + CW'(1);
      else done = 1'b1;
    end
    return n;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] norm(input logic signed [IN_WIDTH-1:0] x,
                                                       input logic [SHIFT_WIDTH-1:0] s);
    logic signed [IN_WIDTH-1:0] sh;
`ifdef CBFP_ROUND_EN
    logic [IN_WIDTH:0]  rnd;
    logic [OUT_WIDTH:0] top;
`endif
    sh = x <<< s;
`ifdef CBFP_ROUND_EN
    // Only a positive carry can overflow, detected where the two top bits disagree.
    rnd = {sh[IN_WIDTH-1], sh} + HALF;
    top = rnd[IN_WIDTH -: OUT_WIDTH+1];
    if (top[OUT_WIDTH] != top[OUT_WIDTH-1]) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    return top[OUT_WIDTH-1:0];
`else
    return sh[IN_WIDTH-1 -: OUT_WIDTH];
`endif
  endfunction

  assign bus.in_ready = rstn && (st_q[wptr_q] == EMPTY || st_q[wptr_q] == FILLING);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign in_last      = (wcnt_q == LAST_IDX);
  assign b_adv        = !bus.out_valid || bus.out_ready;
  assign a_adv        = !a_vld || b_adv;
  assign fetch        = a_adv && (st_q[rptr_q] == FULL || st_q[rptr_q] == DRAINING);
  assign fetch_last   = (rcnt_q == LAST_IDX);

  // A bank is released once its last sample has moved into the output pipeline.
  always_comb begin
    st_d   = st_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (in_fire) begin
      if (in_last) begin
        st_d[wptr_q] = FULL;
        wptr_d       = ~wptr_q;
        wcnt_d       = '0;
      end else begin
        st_d[wptr_q] = FILLING;
        wcnt_d       = wcnt_q + AW'(1);
      end
    end
    if (fetch) begin
      if (fetch_last) begin
        st_d[rptr_q] = EMPTY;
        rptr_d       = ~rptr_q;
        rcnt_d       = '0;
      end else begin
        st_d[rptr_q] = DRAINING;
        rcnt_d       = rcnt_q + AW'(1);
      end
    end
  end

  always_comb begin
    rsb_re  = rsb(bus.in_re);
    rsb_im  = rsb(bus.in_im);
    blk_min = min_q;
    if (rsb_re < blk_min) blk_min = rsb_re;
    if (rsb_im < blk_min) blk_min = rsb_im;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q[0]    <= EMPTY;
      st_q[1]    <= EMPTY;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      min_q      <= MIN_INIT;
      shift_q[0] <= '0;
      shift_q[1] <= '0;
    end else begin
      st_q   <= st_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      if (in_fire) begin
        min_q <= in_last ? MIN_INIT : blk_min;
        if (in_last)
          shift_q[wptr_q] <= (blk_min > SHIFT_CAP) ? SHIFT_WIDTH'(MAX_SHIFT) : SHIFT_WIDTH'(blk_min);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[{wptr_q, wcnt_q}] <= bus.in_re;
      mem_im[{wptr_q, wcnt_q}] <= bus.in_im;
    end
  end

  // Two-deep read pipeline: bank read, then normalise into the output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_vld   <= 1'b0;
      a_last  <= 1'b0;
      a_re    <= '0;
      a_im    <= '0;
      a_shift <= '0;
    end else if (a_adv) begin
      a_vld <= fetch;
      if (fetch) begin
        a_re    <= mem_re[{rptr_q, rcnt_q}];
        a_im    <= mem_im[{rptr_q, rcnt_q}];
        a_last  <= fetch_last;
        a_shift <= shift_q[rptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_shift <= '0;
    end else if (b_adv) begin
      bus.out_valid <= a_vld;
      if (a_vld) begin
        bus.out_re    <= norm(a_re, a_shift);
        bus.out_im    <= norm(a_im, a_shift);
        bus.out_last  <= a_last;
        bus.out_shift <= a_shift;
      end
    end
  end
endmodule
